// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if
//   Bundles the ID/EX inputs, the forwarding/write-back controls, the stall
//   output and the EX/MEM register outputs of the RV32 execute stage.
//
//   modport master : pipeline side (drives ID/EX, observes EX/MEM and stall)
//   modport slave  : execute stage (consumes ID/EX, drives EX/MEM and stall)
// ---------------------------------------------------------------------------
interface execute_stage_if #(
  parameter int XLEN = 32
);
  // ID/EX control
  logic            Ctl_MemtoReg_in;
  logic            Ctl_RegWrite_in;
  logic            Ctl_MemRead_in;
  logic            Ctl_MemWrite_in;
  logic            Ctl_Branch_in;
  logic            jal_in;
  logic            jalr_in;
  logic            ALUSrc_in;
  logic [3:0]      ALU_ctl_in;
  logic            md_valid_in;
  logic [2:0]      md_op_in;
  // ID/EX data
  logic [XLEN-1:0] Rs1_data_in;
  logic [XLEN-1:0] Rs2_data_in;
  logic [XLEN-1:0] Imm_in;
  logic [XLEN-1:0] PC_in;
  logic [4:0]      Rd_in;
  // forwarding / hazard
  logic [1:0]      ForwardA_in;
  logic [1:0]      ForwardB_in;
  logic [XLEN-1:0] WB_data_in;
  logic            flush_in;
  logic            stall_out;
  // EX/MEM register
  logic            Ctl_MemtoReg_out;
  logic            Ctl_RegWrite_out;
  logic            Ctl_MemRead_out;
  logic            Ctl_MemWrite_out;
  logic            Ctl_Branch_out;
  logic            jal_out;
  logic            jalr_out;
  logic            Zero_out;
  logic [4:0]      Rd_out;
  logic [XLEN-1:0] ALUresult_out;
  logic [XLEN-1:0] Write_Data;
  logic [XLEN-1:0] PC_out;

  modport master (
    output Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
           Ctl_Branch_in, jal_in, jalr_in, ALUSrc_in, ALU_ctl_in,
           md_valid_in, md_op_in, Rs1_data_in, Rs2_data_in, Imm_in, PC_in,
           Rd_in, ForwardA_in, ForwardB_in, WB_data_in, flush_in,
    input  stall_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
           Ctl_MemWrite_out, Ctl_Branch_out, jal_out, jalr_out, Zero_out,
           Rd_out, ALUresult_out, Write_Data, PC_out
  );

  modport slave (
    input  Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
           Ctl_Branch_in, jal_in, jalr_in, ALUSrc_in, ALU_ctl_in,
           md_valid_in, md_op_in, Rs1_data_in, Rs2_data_in, Imm_in, PC_in,
           Rd_in, ForwardA_in, ForwardB_in, WB_data_in, flush_in,
    output stall_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
           Ctl_MemWrite_out, Ctl_Branch_out, jal_out, jalr_out, Zero_out,
           Rd_out, ALUresult_out, Write_Data, PC_out
  );
endinterface

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   Execute stage of the 5-stage RV32 pipeline. Selects forwarded operands,
//   runs the single-cycle ALU and (optionally) an iterative radix-2 RV32M
//   multiply/divide unit, and holds the EX/MEM pipeline register.
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous, active-low reset
//     ex    : execute_stage_if.slave (ID/EX inputs, forwarding, flush,
//             stall_out, EX/MEM register outputs)
//
//   Configuration
//     RV32M_EN : when defined, the MD unit and its IDLE/BUSY/DONE FSM are
//                built; otherwise md_valid_in is ignored and stall_out is 0.
// ---------------------------------------------------------------------------
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  execute_stage_if.slave ex
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;

  // EX/MEM register
  logic [6:0]      ctl_q, ctl_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            zero_q, zero_d;

  logic [6:0]      ctl_in;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_result;
  logic            stall;
  logic            md_done;
  logic [XLEN-1:0] md_result, md_wdata;

  assign ctl_in = {ex.Ctl_MemtoReg_in, ex.Ctl_RegWrite_in, ex.Ctl_MemRead_in,
                   ex.Ctl_MemWrite_in, ex.Ctl_Branch_in, ex.jal_in, ex.jalr_in};

  // Operand forwarding: 10 takes the EX/MEM result, 01 the write-back data.
  always_comb begin
    case (ex.ForwardA_in)
      2'b10:   fwd_a = result_q;
      2'b01:   fwd_a = ex.WB_data_in;
      default: fwd_a = ex.Rs1_data_in;
    endcase
    case (ex.ForwardB_in)
      2'b10:   fwd_b = result_q;
      2'b01:   fwd_b = ex.WB_data_in;
      default: fwd_b = ex.Rs2_data_in;
    endcase
    op_b = ex.ALUSrc_in ? ex.Imm_in : fwd_b;
  end

  // Single-cycle ALU
  always_comb begin
    alu_result = '0;
    case (ex.ALU_ctl_in)
      ALU_AND:  alu_result = fwd_a & op_b;
      ALU_OR:   alu_result = fwd_a | op_b;
      ALU_ADD:  alu_result = fwd_a + op_b;
      ALU_SUB:  alu_result = fwd_a - op_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
      ALU_XOR:  alu_result = fwd_a ^ op_b;
      ALU_SLL:  alu_result = fwd_a << op_b[4:0];
      ALU_SRL:  alu_result = fwd_a >> op_b[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(fwd_a) >>> op_b[4:0]);
      default:  alu_result = '0;
    endcase
  end

`ifdef RV32M_EN
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  // hi/lo: product accumulator for multiply, remainder/quotient for divide
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d;
  logic            neg_q, neg_d;
  logic            dz_q, dz_d;

  logic            md_start;
  logic            a_sgn, b_sgn, a_neg, b_neg, is_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_rem;
  logic            div_fit;
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0] div_mag, div_signed;

  assign md_start = (state_q == MD_IDLE) && ex.md_valid_in && !ex.flush_in;
  assign stall    = md_start || (state_q == MD_BUSY);
  assign md_done  = (state_q == MD_DONE);
  assign md_wdata = b_raw_q;

  // Operand magnitudes. MUL treats both operands as unsigned; the low half
  // of the product is the same either way.
  always_comb begin
    is_div = ex.md_op_in[2];
    case (ex.md_op_in)
      3'b001:  {a_sgn, b_sgn} = 2'b11;  // MULH
      3'b010:  {a_sgn, b_sgn} = 2'b10;  // MULHSU
      3'b100:  {a_sgn, b_sgn} = 2'b11;  // DIV
      3'b110:  {a_sgn, b_sgn} = 2'b11;  // REM
      default: {a_sgn, b_sgn} = 2'b00;
    endcase
    a_neg = a_sgn & fwd_a[XLEN-1];
    b_neg = b_sgn & fwd_b[XLEN-1];
    a_mag = a_neg ? -fwd_a : fwd_a;
    b_mag = b_neg ? -fwd_b : fwd_b;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  // When the trial subtract fits, the true difference is below 2^XLEN, so
  // the truncated subtraction is exact.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_fit   = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_shift[XLEN-1:0] - opnd_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    a_raw_d = a_raw_q;
    b_raw_d = b_raw_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = '0;
          op_d    = ex.md_op_in;
          a_raw_d = fwd_a;
          b_raw_d = fwd_b;
          dz_d    = (fwd_b == '0);
          hi_d    = '0;
          if (is_div) begin
            lo_d   = a_mag;
            opnd_d = b_mag;
            // remainder takes the dividend's sign, quotient the xor
            neg_d  = ex.md_op_in[1] ? a_neg : (a_neg ^ b_neg);
          end else begin
            lo_d   = b_mag;
            opnd_d = a_mag;
            neg_d  = a_neg ^ b_neg;
          end
        end
      end
      MD_BUSY: begin
        if (op_q[2]) begin
          hi_d = div_fit ? div_rem : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_fit};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    // flush abandons any operation, including one about to complete
    if (ex.flush_in) begin
      state_d = MD_IDLE;
    end
  end

  // Sign fix-up and divide-by-zero results. The 0x80000000 / -1 overflow
  // case falls out naturally: negating 0x80000000 yields itself.
  always_comb begin
    prod_mag   = {hi_q, lo_q};
    prod       = neg_q ? -prod_mag : prod_mag;
    div_mag    = op_q[1] ? hi_q : lo_q;
    div_signed = neg_q ? -div_mag : div_mag;
    if (!op_q[2]) begin
      md_result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (dz_q) begin
      md_result = op_q[1] ? a_raw_q : {XLEN{1'b1}};
    end else begin
      md_result = div_signed;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      b_raw_q <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      a_raw_q <= a_raw_d;
      b_raw_q <= b_raw_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{ex.md_valid_in, ex.md_op_in};
  assign stall     = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
  assign md_wdata  = '0;
`endif

  // EX/MEM next value: bubble on flush or stall, MD result on completion,
  // ALU result otherwise. ID/EX is still held during DONE, so its control,
  // Rd and PC belong to the MD instruction.
  always_comb begin
    ctl_d    = '0;
    rd_d     = '0;
    result_d = '0;
    wdata_d  = '0;
    pc_d     = '0;
    zero_d   = 1'b0;
    if (!(ex.flush_in || stall)) begin
      ctl_d = ctl_in;
      rd_d  = ex.Rd_in;
      pc_d  = ex.PC_in;
      if (md_done) begin
        result_d = md_result;
        wdata_d  = md_wdata;
      end else begin
        result_d = alu_result;
        wdata_d  = fwd_b;
      end
      zero_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      zero_q   <= 1'b0;
    end else begin
      ctl_q    <= ctl_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      pc_q     <= pc_d;
      zero_q   <= zero_d;
    end
  end

  assign ex.stall_out = stall;
  assign {ex.Ctl_MemtoReg_out, ex.Ctl_RegWrite_out, ex.Ctl_MemRead_out,
          ex.Ctl_MemWrite_out, ex.Ctl_Branch_out, ex.jal_out, ex.jalr_out} = ctl_q;
  assign ex.Rd_out        = rd_q;
  assign ex.ALUresult_out = result_q;
  assign ex.Write_Data    = wdata_q;
  assign ex.PC_out        = pc_q;
  assign ex.Zero_out      = zero_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  execute_stage_if bus ();
  execute_stage dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus)
  );

  typedef struct packed {
    logic [6:0]  ctl;
    logic [3:0]  alu;
    logic        alusrc;
    logic        md;
    logic [2:0]  mdop;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        flush;
  } txn_t;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        zero;
  } exmem_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_prev = '0;  // model's view of the EX/MEM result
  logic [3:0] alu_ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                               4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      $display("FAIL %s: observed %b expected %b", tag, obs, expv);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic check_em(input string tag, input exmem_t obs, input exmem_t expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      $display("FAIL %s: observed ctl=%b rd=%0d res=%h wd=%h pc=%h z=%b expected ctl=%b rd=%0d res=%h wd=%h pc=%h z=%b",
               tag, obs.ctl, obs.rd, obs.res, obs.wdata, obs.pc, obs.zero,
               expv.ctl, expv.rd, expv.res, expv.wdata, expv.pc, expv.zero);
      $error("check %s did not hold", tag);
    end
  endtask

  function automatic exmem_t obs_exmem();
    exmem_t o;
    o.ctl   = {bus.Ctl_MemtoReg_out, bus.Ctl_RegWrite_out, bus.Ctl_MemRead_out,
               bus.Ctl_MemWrite_out, bus.Ctl_Branch_out, bus.jal_out, bus.jalr_out};
    o.rd    = bus.Rd_out;
    o.res   = bus.ALUresult_out;
    o.wdata = bus.Write_Data;
    o.pc    = bus.PC_out;
    o.zero  = bus.Zero_out;
    return o;
  endfunction

  task automatic apply(input txn_t t);
    {bus.Ctl_MemtoReg_in, bus.Ctl_RegWrite_in, bus.Ctl_MemRead_in, bus.Ctl_MemWrite_in,
     bus.Ctl_Branch_in, bus.jal_in, bus.jalr_in} = t.ctl;
    bus.ALU_ctl_in  = t.alu;
    bus.ALUSrc_in   = t.alusrc;
    bus.md_valid_in = t.md;
    bus.md_op_in    = t.mdop;
    bus.Rs1_data_in = t.rs1;
    bus.Rs2_data_in = t.rs2;
    bus.Imm_in      = t.imm;
    bus.PC_in       = t.pc;
    bus.WB_data_in  = t.wb;
    bus.Rd_in       = t.rd;
    bus.ForwardA_in = t.fa;
    bus.ForwardB_in = t.fb;
    bus.flush_in    = t.flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_v,
                                      input logic [31:0] prev, input logic [31:0] wb);
    if (sel == 2'b10) return prev;
    if (sel == 2'b01) return wb;
    return reg_v;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: return (a < b) ? 32'd1 : 32'd0;
      4'b1001: return a ^ b;
      4'b1010: return a << b[4:0];
      4'b1011: return a >> b[4:0];
      4'b1100: return sa >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic exmem_t model_alu(input txn_t t, input logic [31:0] prev);
    exmem_t e;
    logic [31:0] a, rs2, b;
    e = '0;
    if (t.flush) return e;
    a       = fwd(t.fa, t.rs1, prev, t.wb);
    rs2     = fwd(t.fb, t.rs2, prev, t.wb);
    b       = t.alusrc ? t.imm : rs2;
    e.ctl   = t.ctl;
    e.rd    = t.rd;
    e.pc    = t.pc;
    e.res   = alu_ref(t.alu, a, b);
    e.wdata = rs2;
    e.zero  = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    sa = {{32{a[31]}}, a};
    ua = {32'd0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.ctl    = 7'($urandom);
    t.alu    = ($urandom_range(0, 9) < 9) ? alu_ops[$urandom_range(0, 9)] : 4'($urandom);
    t.alusrc = 1'($urandom);
    t.md     = 1'b0;
    t.mdop   = 3'($urandom);
    t.rs1    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    t.rs2    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    t.imm    = $urandom;
    t.pc     = $urandom;
    t.wb     = $urandom;
    t.rd     = 5'($urandom);
    t.fa     = 2'($urandom);
    t.fb     = 2'($urandom);
    t.flush  = ($urandom_range(0, 7) == 0);
    return t;
  endfunction

  task automatic do_alu(input string tag, input txn_t t);
    exmem_t e;
    apply(t);
    e = model_alu(t, exp_prev);
    tick();
    check_em(tag, obs_exmem(), e);
    exp_prev = e.res;
    $display("txn %s alu=%b fa=%b fb=%b flush=%b -> res=%h zero=%b",
             tag, t.alu, t.fa, t.fb, t.flush, bus.ALUresult_out, bus.Zero_out);
  endtask

`ifdef RV32M_EN
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    txn_t t;
    exmem_t e;
    t        = rand_txn();
    t.md     = 1'b1;
    t.mdop   = op;
    t.flush  = 1'b0;
    t.fa     = 2'b00;
    t.fb     = 2'b00;
    t.alusrc = 1'b0;
    t.rs1    = a;
    t.rs2    = b;
    apply(t);
    #1;
    check_bit({tag, "_stall_c0"}, bus.stall_out, 1'b1);
    for (int c = 1; c <= 33; c++) begin
      tick();
      check_bit({tag, "_stall"}, bus.stall_out, (c <= 32));
      check_em({tag, "_bubble"}, obs_exmem(), '0);
      if (c <= 31) begin
        // operand/forwarding changes while busy must have no effect
        bus.Rs1_data_in = $urandom;
        bus.Rs2_data_in = $urandom;
        bus.ForwardA_in = 2'($urandom);
        bus.ForwardB_in = 2'($urandom);
        bus.WB_data_in  = $urandom;
      end else begin
        apply(t);
      end
    end
    tick();
    e       = '0;
    e.ctl   = t.ctl;
    e.rd    = t.rd;
    e.pc    = t.pc;
    e.res   = md_ref(op, a, b);
    e.wdata = b;
    e.zero  = (e.res == 32'd0);
    check_em({tag, "_result"}, obs_exmem(), e);
    exp_prev = e.res;
    $display("txn %s md_op=%0d a=%h b=%h -> res=%h", tag, op, a, b, bus.ALUresult_out);
  endtask
`endif

  initial begin
    txn_t t;
    apply('0);
    // ---------------- reset ----------------
    #2 reset = 1'b0;
    #1;
    check_em("reset_exmem", obs_exmem(), '0);
    check_bit("reset_stall", bus.stall_out, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    exp_prev = '0;

    // ---------------- directed ALU ----------------
    t = '0; t.ctl = 7'b0100000; t.alu = 4'b0010; t.rs1 = 32'd5; t.rs2 = 32'd7;
    t.rd = 5'd3; t.pc = 32'h0000_0100;
    do_alu("add_5_7", t);
    check32("add_5_7_value", bus.ALUresult_out, 32'd12);
    check_bit("add_5_7_zero", bus.Zero_out, 1'b0);

    t = '0; t.ctl = 7'b0100000; t.alu = 4'b0010; t.rs1 = 32'h80; t.rs2 = 32'h80; t.rd = 5'd4;
    do_alu("add_prev", t);
    t = '0; t.ctl = 7'b0100000; t.alu = 4'b0110; t.rs1 = 32'd1; t.fa = 2'b10;
    t.alusrc = 1'b1; t.imm = 32'h100; t.rd = 5'd5;
    do_alu("fwd_sub", t);
    check32("fwd_sub_value", bus.ALUresult_out, 32'd0);
    check_bit("fwd_sub_zero", bus.Zero_out, 1'b1);

    t = '0; t.ctl = 7'b0001000; t.alu = 4'b0010; t.rs1 = 32'd8; t.alusrc = 1'b1;
    t.imm = 32'd4; t.fb = 2'b01; t.wb = 32'hDEAD_0000; t.rs2 = 32'h1111_1111;
    do_alu("fwd_wb_store", t);
    check32("fwd_wb_wdata", bus.Write_Data, 32'hDEAD_0000);

    t.flush = 1'b1;
    do_alu("flush_alu", t);

    // ---------------- asynchronous reset mid-cycle ----------------
    t = '0; t.ctl = 7'b1111111; t.alu = 4'b0001; t.rs1 = 32'h55; t.rd = 5'd9; t.pc = 32'h40;
    do_alu("pre_reset", t);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_em("reset_mid_exmem", obs_exmem(), '0);
    check_bit("reset_mid_stall", bus.stall_out, 1'b0);
    @(negedge clk) reset = 1'b1;
    exp_prev = '0;
    apply('0);

    // ---------------- randomized ALU ----------------
    for (int i = 0; i < 40; i++) begin
      t = rand_txn();
`ifndef RV32M_EN
      t.md = 1'($urandom);
`endif
      apply(t);
      #1;
      check_bit("rand_stall", bus.stall_out, 1'b0);
      do_alu("rand_alu", t);
    end

`ifndef RV32M_EN
    // ---------------- MD request ignored when the unit is absent ----------------
    t = '0; t.ctl = 7'b0100000; t.alu = 4'b0010; t.md = 1'b1; t.mdop = 3'd4;
    t.rs1 = 32'd3; t.rs2 = 32'd4; t.rd = 5'd7;
    apply(t);
    #1;
    check_bit("nom_stall_pre", bus.stall_out, 1'b0);
    do_alu("nom_add", t);
    check32("nom_add_value", bus.ALUresult_out, 32'd7);
    check_bit("nom_stall_post", bus.stall_out, 1'b0);
`else
    // ---------------- MD corners ----------------
    run_md("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check32("mulhu_ff_value", bus.ALUresult_out, 32'hFFFF_FFFE);
    run_md("div_by0", 3'd4, 32'd7, 32'd0);
    check32("div_by0_value", bus.ALUresult_out, 32'hFFFF_FFFF);
    run_md("rem_by0", 3'd6, 32'd7, 32'd0);
    check32("rem_by0_value", bus.ALUresult_out, 32'd7);
    run_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check32("div_ovf_value", bus.ALUresult_out, 32'h8000_0000);
    run_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check32("rem_ovf_value", bus.ALUresult_out, 32'd0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i[0]) rb = rb >> $urandom_range(0, 31);
      run_md("md_rand", 3'(i), ra, rb);
    end

    // ---------------- flush during BUSY ----------------
    t = rand_txn(); t.md = 1'b1; t.mdop = 3'd0; t.flush = 1'b0; t.fa = 2'b00; t.fb = 2'b00;
    t.rs1 = 32'd1234; t.rs2 = 32'd5678;
    apply(t);
    for (int c = 1; c <= 10; c++) begin
      tick();
      check_bit("flush_busy_stall", bus.stall_out, 1'b1);
    end
    bus.flush_in = 1'b1;
    tick();
    apply('0);
    #1;
    check_bit("flush_stall_low", bus.stall_out, 1'b0);
    check_em("flush_bubble", obs_exmem(), '0);
    exp_prev = '0;
    for (int c = 0; c < 30; c++) begin
      do_alu("post_flush_nop", '0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RV32 pipeline, between the ID/EX register and the memory stage. It selects forwarded operands, runs the single-cycle ALU and an optional iterative RV32M multiply/divide unit, and holds the EX/MEM pipeline register that drives the memory stage inputs directly. Multi-cycle operations stall the front of the pipeline through `stall_out` and push bubbles into EX/MEM until the result is ready.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `Ctl_MemtoReg_in`, `Ctl_RegWrite_in`, `Ctl_MemRead_in`, `Ctl_MemWrite_in`, `Ctl_Branch_in`, `jal_in`, `jalr_in` input 1 each: ID/EX control.
- `ALUSrc_in` input 1: 1 selects `Imm_in` as operand B.
- `ALU_ctl_in` input 4: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 XOR, 1010 SLL, 1011 SRL, 1100 SRA; others give 0.
- `md_valid_in` input 1: M-extension instruction. `md_op_in` input 3: funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- `Rs1_data_in`, `Rs2_data_in`, `Imm_in`, `PC_in` input 32. `Rd_in` input 5.
- `ForwardA_in`, `ForwardB_in` input 2: 00 register data, 10 EX/MEM `ALUresult_out`, 01 `WB_data_in`, 11 register data.
- `WB_data_in` input 32: write-back result.
- `flush_in` input 1: kill the instruction in EX.
- `stall_out` output 1: combinational; upstream holds ID/EX while it is high.
- `Ctl_MemtoReg_out`, `Ctl_RegWrite_out`, `Ctl_MemRead_out`, `Ctl_MemWrite_out`, `Ctl_Branch_out`, `jal_out`, `jalr_out`, `Zero_out` output 1 each: EX/MEM register.
- `Rd_out` output 5. `ALUresult_out`, `Write_Data`, `PC_out` output 32: EX/MEM register.

## Operation
- Operand A is the forwarded Rs1. The forwarded Rs2 goes to `Write_Data`. Operand B is `Imm_in` when `ALUSrc_in` is 1, otherwise the forwarded Rs2.
- Shift amount is B[4:0]. SLT is signed and SLTU unsigned; both produce 0 or 1.
- `Zero_out` is 1 when the selected result equals 0.
- The MD FSM has three states: IDLE, BUSY, DONE.
  - IDLE goes to BUSY on `md_valid_in` && !`flush_in`. It latches operands (already forwarded), `md_op_in`, and clears the 5-bit counter.
  - BUSY does one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle, on magnitudes with sign fix-up at the end. It goes to DONE when the counter reaches 31.
  - DONE loads EX/MEM with the MD result and returns to IDLE.
- MUL returns the low 32 bits. MULH, MULHSU and MULHU return the high 32 bits of the signed×signed, signed×unsigned and unsigned×unsigned products.
- Divide by zero: quotient 0xFFFFFFFF, remainder equals the dividend.
- DIV overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- `stall_out` = (IDLE && `md_valid_in` && !`flush_in`) || BUSY.
- While `stall_out` is high, EX/MEM loads a bubble: all control outputs 0, `Rd_out` 0, data fields don't-care (cleared to 0).
- In DONE, EX/MEM loads the held instruction's control, Rd and PC. These are still valid because ID/EX was held.
- `flush_in` at an edge loads a bubble into EX/MEM and forces the FSM to IDLE from any state. Flush has priority over completion.

## Timing
- Reset (low, asynchronous) clears every EX/MEM output to 0, puts the FSM in IDLE and clears `stall_out`. Reset mid-operation abandons the operation.
- ALU ops have 1-cycle latency: the result is in EX/MEM after the first edge.
- MD ops: the instruction arrives in cycle 0 and `stall_out` is high in cycles 0-32. There are 33 BUSY-entry/iteration edges, then DONE in cycle 33 with `stall_out` low. The result is in EX/MEM after edge 34.
- Back-to-back MD ops: the next instruction enters on the edge that leaves DONE and starts in IDLE the next cycle. There is no overlap.
- Forwarding inputs are sampled only in IDLE. Changes during BUSY are ignored.

## Configuration
- `RV32M_EN` defined: MD unit and FSM are compiled in as described.
- `RV32M_EN` not defined:
  - The MD unit is compiled out and `stall_out` is tied to 0.
  - `md_valid_in` is ignored and the ALU path is used.
  - `Zero_out` and `ALUresult_out` reflect `ALU_ctl_in` only.

## Test plan
- Reset: drive `reset` low mid-cycle -> all outputs 0 immediately; after release, ADD 5+7 with `ALU_ctl_in`=0010 -> `ALUresult_out`=12, `Zero_out`=0 one edge later.
- Forwarding: Rs1=1, `ForwardA_in`=10, previous result 0x100, SUB B=0x100 -> `ALUresult_out`=0, `Zero_out`=1.
- MUL: 0xFFFFFFFF × 0xFFFFFFFF, MULHU -> 0xFFFFFFFE after edge 34; `stall_out` high cycles 0-32; bubbles in EX/MEM meanwhile.
- Divide corners: DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Flush during BUSY at cycle 10 -> FSM IDLE, `stall_out` low next cycle, EX/MEM holds a bubble, no result ever written.
- Without `RV32M_EN`: `md_valid_in`=1 with ADD 3+4 -> `stall_out` stays 0, `ALUresult_out`=7 after one edge.
